// File: rtl/nat_mem_arbiter_pkg.sv
// Package nat_arb_pkg: shared sizing, the read-return tag payload and the
// grant-type enum used by the native-port memory arbiter slice.
package nat_arb_pkg;

    localparam int unsigned NCLIENTS  = 2;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned NATIVE_DW = 256;
    localparam int unsigned MAX_OUTST = 4;
    localparam int unsigned CID_W     = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;
    localparam int unsigned TPTR_W    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    // Tag remembered per outstanding read so the return can be routed back.
    typedef struct packed {
        logic [CID_W-1:0]  cid;
        logic [ADDR_W-1:0] addr;
    } rd_tag_t;

    typedef enum logic [1:0] {
        G_NONE  = 2'd0,
        G_WRITE = 2'd1,
        G_READ  = 2'd2
    } grant_e;

    // Round-robin successor of a client id.
    function automatic logic [CID_W-1:0] next_cid(input logic [CID_W-1:0] c);
        return (32'(c) == NCLIENTS - 1) ? '0 : c + CID_W'(1);
    endfunction

endpackage

// File: rtl/nat_mem_arbiter_if.sv
// Native-client and memory-side signal bundle of nat_mem_arbiter.
//  slave  : the arbiter's view
//  master : the environment (clients + backing memory)
interface nat_mem_arbiter_if;
    import nat_arb_pkg::*;

    logic [NCLIENTS-1:0]           cl_wr_valid_i;
    logic [NCLIENTS*ADDR_W-1:0]    cl_wr_addr_i;
    logic [NCLIENTS*NATIVE_DW-1:0] cl_wr_data_i;
    logic [NCLIENTS-1:0]           cl_rd_valid_i;
    logic [NCLIENTS*ADDR_W-1:0]    cl_rd_addr_i;
    logic [NCLIENTS-1:0]           cl_rd_valid_o;
    logic [ADDR_W-1:0]             cl_rd_addr_o;
    logic [NATIVE_DW-1:0]          cl_rd_data_o;
    logic                          mem_req_o;
    logic                          mem_we_o;
    logic [ADDR_W-1:0]             mem_addr_o;
    logic [NATIVE_DW-1:0]          mem_wdata_o;
    logic                          mem_ready_i;
    logic                          mem_rvalid_i;
    logic [NATIVE_DW-1:0]          mem_rdata_i;
    logic                          err_overflow_o;
    logic                          err_spurious_o;

    modport slave (
        input  cl_wr_valid_i, cl_wr_addr_i, cl_wr_data_i, cl_rd_valid_i, cl_rd_addr_i,
        input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
        output cl_rd_valid_o, cl_rd_addr_o, cl_rd_data_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output err_overflow_o, err_spurious_o
    );

    modport master (
        output cl_wr_valid_i, cl_wr_addr_i, cl_wr_data_i, cl_rd_valid_i, cl_rd_addr_i,
        output mem_ready_i, mem_rvalid_i, mem_rdata_i,
        input  cl_rd_valid_o, cl_rd_addr_o, cl_rd_data_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  err_overflow_o, err_spurious_o
    );

endinterface

// File: rtl/nat_mem_arbiter_tag_fifo.sv
// nat_tag_fifo: synchronous FIFO of read tags, depth MAX_OUTST.
//  aclk_i/areset_i : clock, async active-high reset
//  push/push_data  : enqueue (accepted when not full, or when popping the same cycle)
//  pop             : dequeue (ignored when empty)
//  pop_data_c      : head entry (combinational)
//  full_c/empty_c  : occupancy flags (combinational)
module nat_tag_fifo
    import nat_arb_pkg::*;
(
    input  logic    aclk_i,
    input  logic    areset_i,
    input  logic    push,
    input  rd_tag_t push_data,
    input  logic    pop,
    output rd_tag_t pop_data_c,
    output logic    full_c,
    output logic    empty_c
);

    localparam int unsigned CNT_W = TPTR_W + 1;

    rd_tag_t           mem_q [MAX_OUTST];
    logic [TPTR_W-1:0] wr_ptr_q;
    logic [TPTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              do_push;
    logic              do_pop;

    assign full_c     = (cnt_q == CNT_W'(MAX_OUTST));
    assign empty_c    = (cnt_q == '0);
    assign do_pop     = pop && !empty_c;
    // A pop in the same cycle frees the head, so a push into a full FIFO is legal then.
    assign do_push    = push && (!full_c || do_pop);
    assign pop_data_c = mem_q[rd_ptr_q];

    // Pointers and occupancy.
    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + TPTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + TPTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage, qualified by the pointers so it needs no reset.
    always_ff @(posedge aclk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/nat_mem_arbiter.sv
// nat_mem_arbiter: captures per-client native write/read pulses in slots,
// round-robins them onto one in-order memory port and routes read data back.
//  aclk_i   : clock
//  areset_i : async active-high reset
//  bus      : client pulses/returns, memory request/response, sticky errors
module nat_mem_arbiter
    import nat_arb_pkg::*;
(
    input  logic             aclk_i,
    input  logic             areset_i,
    nat_mem_arbiter_if.slave bus
);

    logic [NCLIENTS-1:0]  wr_vld_q;
    logic [NCLIENTS-1:0]  rd_vld_q;
    logic [ADDR_W-1:0]    wr_addr_q [NCLIENTS];
    logic [NATIVE_DW-1:0] wr_data_q [NCLIENTS];
    logic [ADDR_W-1:0]    rd_addr_q [NCLIENTS];

    logic [CID_W-1:0]     rr_ptr_q;
    logic                 lock_vld_q;
    logic [CID_W-1:0]     lock_cid_q;
    grant_e               lock_gnt_q;

    grant_e               gnt_type_c;
    logic [CID_W-1:0]     gnt_cid_c;
    logic                 accept_c;
    logic [NCLIENTS-1:0]  wr_take_c;
    logic [NCLIENTS-1:0]  rd_take_c;
    logic [NCLIENTS-1:0]  wr_load_c;
    logic [NCLIENTS-1:0]  rd_load_c;
    logic                 overflow_c;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    rd_tag_t              fifo_head;
    rd_tag_t              fifo_in;

    logic [NCLIENTS-1:0]  ret_vld_q;
    logic [ADDR_W-1:0]    ret_addr_q;
    logic [NATIVE_DW-1:0] ret_data_q;
    logic                 err_ovf_q;
    logic                 err_spur_q;

    // Round-robin grant; a request not yet accepted is replayed from the lock
    // so a newly eligible client can never steal an in-flight request.
    always_comb begin
        logic [CID_W-1:0] cid_v;
        int unsigned      cand;
        gnt_type_c = G_NONE;
        gnt_cid_c  = '0;
        cid_v      = '0;
        cand       = 0;
        if (lock_vld_q) begin
            gnt_type_c = lock_gnt_q;
            gnt_cid_c  = lock_cid_q;
        end else begin
            for (int unsigned i = 0; i < NCLIENTS; i++) begin
                cand = 32'(rr_ptr_q) + i;
                if (cand >= NCLIENTS) cand = cand - NCLIENTS;
                cid_v = CID_W'(cand);
                if (gnt_type_c == G_NONE) begin
                    if (wr_vld_q[cid_v]) begin
                        gnt_type_c = G_WRITE;
                        gnt_cid_c  = cid_v;
                    end else if (rd_vld_q[cid_v] && !fifo_full) begin
                        gnt_type_c = G_READ;
                        gnt_cid_c  = cid_v;
                    end
                end
            end
        end
    end

    assign bus.mem_req_o   = (gnt_type_c != G_NONE);
    assign bus.mem_we_o    = (gnt_type_c == G_WRITE);
    assign bus.mem_addr_o  = (gnt_type_c == G_WRITE) ? wr_addr_q[gnt_cid_c] :
                             (gnt_type_c == G_READ)  ? rd_addr_q[gnt_cid_c] : '0;
    assign bus.mem_wdata_o = (gnt_type_c == G_WRITE) ? wr_data_q[gnt_cid_c] : '0;
    assign accept_c        = bus.mem_req_o && bus.mem_ready_i;

    // Slot release on acceptance, refill decisions and overflow detection.
    always_comb begin
        wr_take_c = '0;
        rd_take_c = '0;
        if (accept_c && gnt_type_c == G_WRITE) wr_take_c[gnt_cid_c] = 1'b1;
        if (accept_c && gnt_type_c == G_READ)  rd_take_c[gnt_cid_c] = 1'b1;
        wr_load_c  = bus.cl_wr_valid_i & (~wr_vld_q | wr_take_c);
        rd_load_c  = bus.cl_rd_valid_i & (~rd_vld_q | rd_take_c);
        overflow_c = |(bus.cl_wr_valid_i & ~wr_load_c) || |(bus.cl_rd_valid_i & ~rd_load_c);
    end

    // Slot occupancy, RR pointer and grant lock.
    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            wr_vld_q   <= '0;
            rd_vld_q   <= '0;
            rr_ptr_q   <= '0;
            lock_vld_q <= 1'b0;
            lock_cid_q <= '0;
            lock_gnt_q <= G_NONE;
        end else begin
            wr_vld_q   <= wr_load_c | (wr_vld_q & ~wr_take_c);
            rd_vld_q   <= rd_load_c | (rd_vld_q & ~rd_take_c);
            if (accept_c) rr_ptr_q <= next_cid(gnt_cid_c);
            lock_vld_q <= bus.mem_req_o && !bus.mem_ready_i;
            lock_cid_q <= gnt_cid_c;
            lock_gnt_q <= gnt_type_c;
        end
    end

    // Slot payloads, only meaningful while the matching valid bit is set.
    always_ff @(posedge aclk_i) begin
        for (int unsigned c = 0; c < NCLIENTS; c++) begin
            if (wr_load_c[c]) begin
                wr_addr_q[c] <= bus.cl_wr_addr_i[c*ADDR_W +: ADDR_W];
                wr_data_q[c] <= bus.cl_wr_data_i[c*NATIVE_DW +: NATIVE_DW];
            end
            if (rd_load_c[c]) rd_addr_q[c] <= bus.cl_rd_addr_i[c*ADDR_W +: ADDR_W];
        end
    end

    assign fifo_push    = accept_c && (gnt_type_c == G_READ);
    assign fifo_pop     = bus.mem_rvalid_i && !fifo_empty;
    assign fifo_in.cid  = gnt_cid_c;
    assign fifo_in.addr = rd_addr_q[gnt_cid_c];

    nat_tag_fifo u_tag_fifo (
        .aclk_i     (aclk_i),
        .areset_i   (areset_i),
        .push       (fifo_push),
        .push_data  (fifo_in),
        .pop        (fifo_pop),
        .pop_data_c (fifo_head),
        .full_c     (fifo_full),
        .empty_c    (fifo_empty)
    );

    // Read-return stage and sticky error flags.
    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            ret_vld_q  <= '0;
            ret_addr_q <= '0;
            ret_data_q <= '0;
            err_ovf_q  <= 1'b0;
            err_spur_q <= 1'b0;
        end else begin
            ret_vld_q  <= '0;
            ret_addr_q <= '0;
            ret_data_q <= '0;
            if (fifo_pop) begin
                ret_vld_q[fifo_head.cid] <= 1'b1;
                ret_addr_q               <= fifo_head.addr;
                ret_data_q               <= bus.mem_rdata_i;
            end
            if (overflow_c)                       err_ovf_q  <= 1'b1;
            if (bus.mem_rvalid_i && fifo_empty)   err_spur_q <= 1'b1;
        end
    end

    assign bus.cl_rd_valid_o  = ret_vld_q;
    assign bus.cl_rd_addr_o   = ret_addr_q;
    assign bus.cl_rd_data_o   = ret_data_q;
    assign bus.err_overflow_o = err_ovf_q;
    assign bus.err_spurious_o = err_spur_q;

endmodule

// File: tb/tb_nat_mem_arbiter.sv
// Directed bench for nat_mem_arbiter: write issue, dual-client reads with
// in-order returns, back-pressure stability, tag FIFO full, overflow, reset.
module tb_nat_mem_arbiter;
    import nat_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [NATIVE_DW-1:0] D1  = {32{8'hA5}};
    localparam logic [NATIVE_DW-1:0] R0  = {32{8'h11}};
    localparam logic [NATIVE_DW-1:0] R1  = {32{8'h22}};
    localparam logic [NATIVE_DW-1:0] W3  = {32{8'h3C}};
    localparam logic [NATIVE_DW-1:0] R3  = {32{8'h33}};
    localparam logic [NATIVE_DW-1:0] W4  = {32{8'h44}};
    localparam logic [NATIVE_DW-1:0] R4  = {32{8'h55}};
    localparam logic [NATIVE_DW-1:0] W5A = {32{8'h5A}};
    localparam logic [NATIVE_DW-1:0] W5B = {32{8'hB5}};

    nat_mem_arbiter_if bus ();

    nat_mem_arbiter dut (
        .aclk_i   (clk),
        .areset_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [NATIVE_DW-1:0] obs,
                       input logic [NATIVE_DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int c, input logic [ADDR_W-1:0] a, input logic [NATIVE_DW-1:0] d);
        bus.cl_wr_valid_i[c] = 1'b1;
        bus.cl_wr_addr_i[c*ADDR_W +: ADDR_W] = a;
        bus.cl_wr_data_i[c*NATIVE_DW +: NATIVE_DW] = d;
    endtask

    task automatic rd(input int c, input logic [ADDR_W-1:0] a);
        bus.cl_rd_valid_i[c] = 1'b1;
        bus.cl_rd_addr_i[c*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic clr();
        bus.cl_wr_valid_i = '0;
        bus.cl_rd_valid_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_req(input string tag, input logic req, input logic we,
                           input logic [ADDR_W-1:0] a);
        chk({tag, "_req"}, NATIVE_DW'(bus.mem_req_o), NATIVE_DW'(req));
        if (req) begin
            chk({tag, "_we"},   NATIVE_DW'(bus.mem_we_o),   NATIVE_DW'(we));
            chk({tag, "_addr"}, NATIVE_DW'(bus.mem_addr_o), NATIVE_DW'(a));
        end
    endtask

    task automatic chk_ret(input string tag, input logic [NCLIENTS-1:0] v,
                           input logic [ADDR_W-1:0] a, input logic [NATIVE_DW-1:0] d);
        chk({tag, "_vld"},  NATIVE_DW'(bus.cl_rd_valid_o), NATIVE_DW'(v));
        chk({tag, "_addr"}, NATIVE_DW'(bus.cl_rd_addr_o),  NATIVE_DW'(a));
        chk({tag, "_data"}, bus.cl_rd_data_o, d);
    endtask

    initial begin
        bus.cl_wr_valid_i = '0;
        bus.cl_wr_addr_i  = '0;
        bus.cl_wr_data_i  = '0;
        bus.cl_rd_valid_i = '0;
        bus.cl_rd_addr_i  = '0;
        bus.mem_ready_i   = 1'b0;
        bus.mem_rvalid_i  = 1'b0;
        bus.mem_rdata_i   = '0;

        // Reset state
        step();
        step();
        chk("rst_req",  NATIVE_DW'(bus.mem_req_o),      '0);
        chk("rst_rdv",  NATIVE_DW'(bus.cl_rd_valid_o),  '0);
        chk("rst_ovf",  NATIVE_DW'(bus.err_overflow_o), '0);
        chk("rst_spur", NATIVE_DW'(bus.err_spurious_o), '0);
        rst = 1'b0;

        // 1. Single write from client 0
        bus.mem_ready_i = 1'b1;
        wr(0, 32'h100, D1);
        step();
        clr();
        chk_req("t1_issue", 1'b1, 1'b1, 32'h100);
        chk("t1_wdata", bus.mem_wdata_o, D1);
        step();
        chk_req("t1_done", 1'b0, 1'b0, '0);

        // 2. Both clients read the same cycle; c0 first, returns in order
        do_reset();
        bus.mem_ready_i = 1'b1;
        rd(0, 32'h40);
        rd(1, 32'h80);
        step();
        clr();
        chk_req("t2_c0", 1'b1, 1'b0, 32'h40);
        chk("t2_wdata0", bus.mem_wdata_o, '0);
        step();
        chk_req("t2_c1", 1'b1, 1'b0, 32'h80);
        step();
        chk_req("t2_idle", 1'b0, 1'b0, '0);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = R0;
        step();
        chk_ret("t2_ret0", 2'b01, 32'h40, R0);
        bus.mem_rdata_i  = R1;
        step();
        bus.mem_rvalid_i = 1'b0;
        chk_ret("t2_ret1", 2'b10, 32'h80, R1);
        step();
        chk("t2_ret_idle", NATIVE_DW'(bus.cl_rd_valid_o), '0);

        // 3. Write+read pending on c0 under back-pressure
        bus.mem_ready_i = 1'b0;
        wr(0, 32'h200, W3);
        rd(0, 32'h300);
        step();
        clr();
        chk_req("t3_first", 1'b1, 1'b1, 32'h200);
        for (int k = 0; k < 5; k++) begin
            step();
            chk_req("t3_hold", 1'b1, 1'b1, 32'h200);
            chk("t3_hold_wdata", bus.mem_wdata_o, W3);
        end
        bus.mem_ready_i = 1'b1;
        step();
        chk_req("t3_read", 1'b1, 1'b0, 32'h300);
        step();
        chk_req("t3_idle", 1'b0, 1'b0, '0);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = R3;
        step();
        bus.mem_rvalid_i = 1'b0;
        chk_ret("t3_ret", 2'b01, 32'h300, R3);

        // 4. Tag FIFO full: reads held, writes still issue
        do_reset();
        bus.mem_ready_i = 1'b1;
        rd(0, 32'h10);
        rd(1, 32'h14);
        step();
        clr();
        step();
        step();
        rd(0, 32'h18);
        rd(1, 32'h1C);
        step();
        clr();
        chk_req("t4_r3", 1'b1, 1'b0, 32'h18);
        step();
        chk_req("t4_r4", 1'b1, 1'b0, 32'h1C);
        step();
        chk_req("t4_full_idle", 1'b0, 1'b0, '0);
        rd(0, 32'h20);
        wr(1, 32'h24, W4);
        step();
        clr();
        chk_req("t4_wr_passes", 1'b1, 1'b1, 32'h24);
        step();
        chk_req("t4_rd_held", 1'b0, 1'b0, '0);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = R4;
        step();
        bus.mem_rvalid_i = 1'b0;
        chk_ret("t4_ret", 2'b01, 32'h10, R4);
        chk_req("t4_rd_freed", 1'b1, 1'b0, 32'h20);
        step();
        chk_req("t4_idle", 1'b0, 1'b0, '0);

        // 5. Overflow on occupied c1 write slot; original data kept
        do_reset();
        bus.mem_ready_i = 1'b0;
        wr(1, 32'h500, W5A);
        step();
        clr();
        chk_req("t5_first", 1'b1, 1'b1, 32'h500);
        chk("t5_ovf0", NATIVE_DW'(bus.err_overflow_o), '0);
        wr(1, 32'h600, W5B);
        step();
        clr();
        chk("t5_ovf1", NATIVE_DW'(bus.err_overflow_o), NATIVE_DW'(1'b1));
        chk_req("t5_keep", 1'b1, 1'b1, 32'h500);
        chk("t5_keep_wdata", bus.mem_wdata_o, W5A);
        bus.mem_ready_i = 1'b1;
        step();
        chk_req("t5_done", 1'b0, 1'b0, '0);
        chk("t5_ovf_sticky", NATIVE_DW'(bus.err_overflow_o), NATIVE_DW'(1'b1));

        // 6. Reset with reads outstanding, then a stale rvalid
        do_reset();
        bus.mem_ready_i = 1'b1;
        rd(0, 32'h40);
        rd(1, 32'h80);
        step();
        clr();
        step();
        step();
        bus.mem_ready_i = 1'b0;
        wr(0, 32'h700, W3);
        step();
        clr();
        chk_req("t6_pending", 1'b1, 1'b1, 32'h700);
        rst = 1'b1;
        #1;
        chk("t6_async_req", NATIVE_DW'(bus.mem_req_o),      '0);
        chk("t6_async_we",  NATIVE_DW'(bus.mem_we_o),       '0);
        chk("t6_async_ovf", NATIVE_DW'(bus.err_overflow_o), '0);
        step();
        rst = 1'b0;
        bus.mem_ready_i  = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = R0;
        step();
        bus.mem_rvalid_i = 1'b0;
        chk("t6_spur", NATIVE_DW'(bus.err_spurious_o), NATIVE_DW'(1'b1));
        chk("t6_no_ret", NATIVE_DW'(bus.cl_rd_valid_o), '0);
        chk("t6_no_req", NATIVE_DW'(bus.mem_req_o), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
